mem_data_interface: RTL and testbench

- Memory-side stage that sits on the shared 32-bit CPU bus. It contains the MAR and MDR and consumes bus contents through load strobes.
- Runs read/write transactions against the synchronous RAM using a req/ack handshake.
- Drives the MDR value back out as a bus-mux source.
- A small FSM sequences each transaction. A done pulse tells the control unit when the MDR holds valid read data or a write has committed.

---
 rtl/mem_data_interface.sv | 159 +++++++++++++++
 tb/tb_mem_data_interface.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_interface.sv
// mem_data_interface: memory-side stage of the shared 32-bit CPU bus.
// Holds the MAR and MDR. Both registers are loaded from the bus by strobes.
// A small FSM (IDLE -> REQ -> DONE) runs one req/ack transaction against
// the synchronous RAM at a time. The MDR is driven back out as a bus-mux
// source.
//
// Optional feature: define MEM_TIMEOUT_EN to compile in a wait watchdog.
// The watchdog aborts a REQ that gets no mem_ack within TIMEOUT cycles and
// then raises the sticky err flag. Without the macro, REQ waits
// indefinitely and err is tied low.

module mem_data_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       mdr_out,
    output logic [ADDR_W-1:0] mar_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [31:0]       mdr;
    logic              timeout_hit;

    // The address and data registers feed the RAM and the bus directly,
    // so a transaction sees exactly what was latched in IDLE.
    assign mem_addr  = mar;
    assign mar_out   = mar;
    assign mem_wdata = mdr;
    assign mdr_out   = mdr;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The abort fires on the last allowed REQ cycle without an ack.
    // An ack in that same cycle still wins and completes normally.
    assign timeout_hit = (state == REQ) && !mem_ack
                         && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign err = err_q;

    // The wait counter is held at zero outside REQ, so it always starts
    // fresh on entry. The err flag is sticky until clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if ((state == REQ) && !mem_ack) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    // Watchdog compiled out: REQ waits for mem_ack forever.
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;

    // TIMEOUT only matters with the watchdog, so nothing is built from it here.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // Transaction sequencer. The MAR/MDR loads and all handshake outputs
    // are registered in a single block.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (mar_in) begin
                        mar <= bus_in[ADDR_W-1:0];
                    end
                    if (mdr_in) begin
                        mdr <= bus_in;
                    end
                    // Read has priority, so a simultaneous write is dropped.
                    if (read || write) begin
                        state   <= REQ;
                        mem_req <= 1'b1;
                        mem_we  <= !read;
                        busy    <= 1'b1;
                    end
                end

                REQ: begin
                    // Loads and starts are ignored here to keep the address
                    // and data stable.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            mdr <= mem_rdata;
                        end
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_data_interface.sv
// tb_mem_data_interface: directed, table-driven bench for mem_data_interface.
// Inputs are driven on the falling edge. Outputs are sampled on the next
// falling edge, after the rising edge has consumed the inputs.

module tb_mem_data_interface;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr;
    logic [31:0]       bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              read;
    logic              write;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mdr_out;
    logic [ADDR_W-1:0] mar_out;
    logic              busy;
    logic              done;
    logic              err;

    int passed = 0;
    int total  = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic        clr;
        logic [31:0] bus;
        logic        mar_ld;
        logic        mdr_ld;
        logic        rd;
        logic        wr;
        logic [31:0] rdata;
        logic        ack;
        logic        exp_req;
        logic        exp_we;
        logic [8:0]  exp_addr;
        logic [31:0] exp_mdr;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    mem_data_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus_in    (bus_in),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .read      (read),
        .write     (write),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mdr_out   (mdr_out),
        .mar_out   (mar_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison: steps the counters and reports any difference.
    function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic addVec(input logic c, input logic [31:0] b, input logic ml, input logic dl,
                          input logic r, input logic w, input logic [31:0] rd, input logic a,
                          input logic ereq, input logic ewe, input logic [8:0] eaddr,
                          input logic [31:0] emdr, input logic ebusy, input logic edone);
        vec_t v;
        v.clr = c; v.bus = b; v.mar_ld = ml; v.mdr_ld = dl; v.rd = r; v.wr = w;
        v.rdata = rd; v.ack = a; v.exp_req = ereq; v.exp_we = ewe; v.exp_addr = eaddr;
        v.exp_mdr = emdr; v.exp_busy = ebusy; v.exp_done = edone;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        clr = v.clr; bus_in = v.bus; mar_in = v.mar_ld; mdr_in = v.mdr_ld;
        read = v.rd; write = v.wr; mem_rdata = v.rdata; mem_ack = v.ack;
    endtask

    task automatic idleInputs();
        clr = 1'b0; bus_in = '0; mar_in = 1'b0; mdr_in = 1'b0;
        read = 1'b0; write = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, ".mem_req"},   32'(mem_req),   32'(v.exp_req));
        checkVal({tag, ".mem_we"},    32'(mem_we),    32'(v.exp_we));
        checkVal({tag, ".mem_addr"},  32'(mem_addr),  32'(v.exp_addr));
        checkVal({tag, ".mar_out"},   32'(mar_out),   32'(v.exp_addr));
        checkVal({tag, ".mdr_out"},   mdr_out,        v.exp_mdr);
        checkVal({tag, ".mem_wdata"}, mem_wdata,      v.exp_mdr);
        checkVal({tag, ".busy"},      32'(busy),      32'(v.exp_busy));
        checkVal({tag, ".done"},      32'(done),      32'(v.exp_done));
        checkVal({tag, ".err"},       32'(err),       32'(exp_err));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int req_cycles;
        int done_seen;
        logic req_dropped;

        idleInputs();

        //      clr bus           mar mdr rd wr rdata        ack | req we addr    mdr          busy done
        addVec(1, 32'h0,          0, 0, 0, 0, 32'h0,        0,   0, 0, 9'h000, 32'h0,        0, 0); // reset
        addVec(0, 32'h000000A5,   1, 0, 0, 0, 32'h0,        0,   0, 0, 9'h0A5, 32'h0,        0, 0); // load MAR
        addVec(0, 32'hDEADBEEF,   0, 1, 0, 0, 32'h0,        0,   0, 0, 9'h0A5, 32'hDEADBEEF, 0, 0); // load MDR
        addVec(0, 32'h0,          0, 0, 0, 1, 32'h0,        0,   1, 1, 9'h0A5, 32'hDEADBEEF, 1, 0); // write start
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   1, 1, 9'h0A5, 32'hDEADBEEF, 1, 0); // REQ wait 1
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   1, 1, 9'h0A5, 32'hDEADBEEF, 1, 0); // REQ wait 2
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h55555555, 1,   0, 0, 9'h0A5, 32'hDEADBEEF, 1, 1); // write ack
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   0, 0, 9'h0A5, 32'hDEADBEEF, 0, 0); // back to IDLE
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h77777777, 1,   0, 0, 9'h0A5, 32'hDEADBEEF, 0, 0); // stray ack idle
        addVec(0, 32'h00000003,   1, 0, 1, 0, 32'h0,        0,   1, 0, 9'h003, 32'hDEADBEEF, 1, 0); // load+read
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h12345678, 1,   0, 0, 9'h003, 32'h12345678, 1, 1); // min-latency ack
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   0, 0, 9'h003, 32'h12345678, 0, 0); // IDLE
        addVec(0, 32'h0,          0, 0, 1, 1, 32'h0,        0,   1, 0, 9'h003, 32'h12345678, 1, 0); // read+write
        addVec(0, 32'hFFFFFFFF,   1, 1, 0, 1, 32'h0,        0,   1, 0, 9'h003, 32'h12345678, 1, 0); // loads in REQ
        addVec(0, 32'h0,          0, 0, 0, 0, 32'hCAFEF00D, 1,   0, 0, 9'h003, 32'hCAFEF00D, 1, 1); // read ack
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   0, 0, 9'h003, 32'hCAFEF00D, 0, 0); // IDLE
        addVec(0, 32'h000001C4,   1, 0, 1, 0, 32'h0,        0,   1, 0, 9'h1C4, 32'hCAFEF00D, 1, 0); // same-cycle load
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0BADC0DE, 1,   0, 0, 9'h1C4, 32'h0BADC0DE, 1, 1); // ack
        addVec(0, 32'h0,          0, 0, 0, 0, 32'h0,        0,   0, 0, 9'h1C4, 32'h0BADC0DE, 0, 0); // IDLE
        addVec(0, 32'hFFFFFE07,   1, 0, 0, 0, 32'h0,        0,   0, 0, 9'h007, 32'h0BADC0DE, 0, 0); // MAR truncation
        addVec(0, 32'h00000155,   1, 1, 0, 0, 32'h0,        0,   0, 0, 9'h155, 32'h00000155, 0, 0); // dual load

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a REQ; a late ack must not produce done.
        idleInputs();
        bus_in = 32'h0000001F; mar_in = 1'b1; read = 1'b1;
        step();
        checkVal("rst.req_before", 32'(mem_req), 32'd1);
        checkVal("rst.addr_before", 32'(mem_addr), 32'h1F);
        idleInputs();
        clr = 1'b1;
        step();
        checkVal("rst.mem_req", 32'(mem_req), 32'd0);
        checkVal("rst.mem_we", 32'(mem_we), 32'd0);
        checkVal("rst.busy", 32'(busy), 32'd0);
        checkVal("rst.mar", 32'(mar_out), 32'd0);
        checkVal("rst.mdr", mdr_out, 32'd0);
        checkVal("rst.err", 32'(err), 32'd0);
        idleInputs();
        step();
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        step();
        checkVal("rst.late_ack_done", 32'(done), 32'd0);
        checkVal("rst.late_ack_busy", 32'(busy), 32'd0);
        checkVal("rst.late_ack_mdr", mdr_out, 32'd0);
        idleInputs();

        // A start presented during DONE is not queued.
        read = 1'b1;
        step();
        read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        checkVal("noq.done", 32'(done), 32'd1);
        checkVal("noq.mdr", mdr_out, 32'hA5A5A5A5);
        mem_ack = 1'b0; write = 1'b1;
        step();
        checkVal("noq.idle_busy", 32'(busy), 32'd0);
        checkVal("noq.idle_req", 32'(mem_req), 32'd0);
        write = 1'b0;
        step();
        checkVal("noq.still_idle", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // The watchdog aborts after TIMEOUT REQ cycles, keeps MDR and sets err.
        bus_in = 32'h11112222; mdr_in = 1'b1; mar_in = 1'b1;
        step();
        idleInputs();
        read = 1'b1;
        step();
        idleInputs();
        req_cycles = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) req_cycles++;
            step();
        end
        checkVal("to.done", 32'(done), 32'd1);
        checkVal("to.req_cycles", 32'(req_cycles), 32'(TIMEOUT));
        checkVal("to.mdr_kept", mdr_out, 32'h11112222);
        exp_err = 1'b1;
        checkVal("to.err", 32'(err), 32'(exp_err));
        step();
        read = 1'b1;
        step();
        read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33334444;
        step();
        mem_ack = 1'b0;
        checkVal("to.read_done", 32'(done), 32'd1);
        checkVal("to.read_mdr", mdr_out, 32'h33334444);
        checkVal("to.err_sticky", 32'(err), 32'(exp_err));
        step();
        checkVal("to.err_sticky2", 32'(err), 32'(exp_err));
`else
        // Without the watchdog, REQ holds for as long as the ack is missing.
        read = 1'b1;
        step();
        read = 1'b0;
        done_seen = 0;
        req_dropped = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (done) done_seen++;
            if (!mem_req) req_dropped = 1'b1;
            step();
        end
        checkVal("nto.done_count", 32'(done_seen), 32'd0);
        checkVal("nto.req_held", 32'(req_dropped), 32'd0);
        checkVal("nto.err", 32'(err), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h5A5A0001;
        step();
        mem_ack = 1'b0;
        checkVal("nto.done", 32'(done), 32'd1);
        checkVal("nto.mdr", mdr_out, 32'h5A5A0001);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
